// File: rtl/jericalla_seg.sv
// Two-stage operand-bank -> ALU pipeline with valid/ready handshakes on both ends.
// The result is written to a small RAM as it enters the output stage.
module jericalla_seg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3*ADDR_W+OP_W:0]    instruccion,
  input  logic                      in_valido,
  output logic                      in_listo,
  input  logic                      carga_en,
  input  logic [ADDR_W-1:0]         carga_dir,
  input  logic [DATA_W-1:0]         carga_dato,
  input  logic [ADDR_W-1:0]         rd_dir,
  output logic [DATA_W-1:0]         rd_dato,
  output logic [DATA_W-1:0]         salida,
  output logic                      Zflag,
  output logic                      Cflag,
  output logic                      out_valido,
  input  logic                      out_listo,
  output logic [CNT_W-1:0]          contador_ops
);
  localparam int IW    = 3*ADDR_W+OP_W+1;
  localparam int DEPTH = 2**ADDR_W;

  localparam logic [OP_W-1:0] OP_AND = OP_W'(0);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLT = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NOR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLL = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SRL = OP_W'(8);

  logic [ADDR_W-1:0] in_dir, in_a, in_b;
  logic [OP_W-1:0]   in_op;
  logic              in_en;

  assign in_dir = instruccion[IW-1 -: ADDR_W];
  assign in_op  = instruccion[IW-1-ADDR_W -: OP_W];
  assign in_a   = instruccion[IW-1-ADDR_W-OP_W -: ADDR_W];
  assign in_b   = instruccion[ADDR_W:1];
  assign in_en  = instruccion[0];

  logic [DATA_W-1:0] bank_q [DEPTH];
  logic [DATA_W-1:0] ram_q  [DEPTH];

  logic              v1_q, v1_d;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] dir_q;
  logic              en_q;

  logic              ov_q, ov_d;
  logic [DATA_W-1:0] res_q;
  logic              z_q, c_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic adv1, adv2, accept;

  assign adv2   = ~ov_q | out_listo;
  assign adv1   = ~v1_q | adv2;
  assign accept = in_valido & adv1;

  assign in_listo     = adv1;
  assign out_valido   = ov_q;
  assign salida       = res_q;
  assign Zflag        = z_q;
  assign Cflag        = c_q;
  assign contador_ops = cnt_q;
  assign rd_dato      = ram_q[rd_dir];

  // ALU on the S1 registers
  logic [DATA_W-1:0] res;
  logic              cy;
  logic [4:0]        shamt;

  always_comb begin
    res   = '0;
    cy    = 1'b0;
    shamt = b_q[4:0];
    case (op_q)
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_ADD: {cy, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        res = a_q - b_q;
        cy  = (a_q < b_q);
      end
      OP_SLT: res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      OP_NOR: res = ~(a_q | b_q);
      OP_XOR: res = a_q ^ b_q;
      OP_SLL: res = a_q << shamt;
      OP_SRL: res = a_q >> shamt;
      default: res = '0;
    endcase
  end

  always_comb begin
    v1_d  = adv1 ? accept : v1_q;
    ov_d  = adv2 ? v1_q : ov_q;
    cnt_d = (ov_q & out_listo) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      ov_q  <= 1'b0;
      res_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      dir_q <= '0;
      en_q  <= 1'b0;
    end else begin
      v1_q  <= v1_d;
      ov_q  <= ov_d;
      cnt_q <= cnt_d;
      if (adv1 && accept) begin
        a_q   <= bank_q[in_a];
        b_q   <= bank_q[in_b];
        op_q  <= in_op;
        dir_q <= in_dir;
        en_q  <= in_en;
      end
      if (adv2 && v1_q) begin
        res_q <= res;
        z_q   <= (res == '0);
        c_q   <= cy;
      end
    end
  end

  // Bank read in S1 sees the pre-load value when a load hits the same address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
    end else if (carga_en) begin
      bank_q[carga_dir] <= carga_dato;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (v1_q && adv2 && en_q) begin
      ram_q[dir_q] <= res;
    end
  end

endmodule

// File: tb/tb_jericalla_seg.sv
// Bench for jericalla_seg: directed vector table, handshake corner sequences,
// then randomized traffic scored against a transaction-level reference.
module tb_jericalla_seg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] instruccion;
  logic        in_valido, in_listo;
  logic        carga_en;
  logic [3:0]  carga_dir;
  logic [31:0] carga_dato;
  logic [3:0]  rd_dir;
  logic [31:0] rd_dato, salida;
  logic        Zflag, Cflag, out_valido, out_listo;
  logic [15:0] contador_ops;

  int checks = 0;
  int errors = 0;

  jericalla_seg dut (
    .clk(clk), .rst_n(rst_n), .instruccion(instruccion),
    .in_valido(in_valido), .in_listo(in_listo),
    .carga_en(carga_en), .carga_dir(carga_dir), .carga_dato(carga_dato),
    .rd_dir(rd_dir), .rd_dato(rd_dato), .salida(salida),
    .Zflag(Zflag), .Cflag(Cflag), .out_valido(out_valido),
    .out_listo(out_listo), .contador_ops(contador_ops)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, exp;
    logic        z, c, en;
    logic [3:0]  dir;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic        z, c;
  } res_t;

  vec_t        tv [16];
  logic [31:0] mbank [16];
  logic [31:0] mram  [16];
  res_t        exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [16:0] mk_ins(input logic [3:0] dir, input logic [3:0] op,
                                         input logic [3:0] a, input logic [3:0] b,
                                         input logic en);
    return {dir, op, a, b, en};
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input logic z, input logic c,
                              input logic en, input logic [3:0] dir);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp; v.z = z; v.c = c; v.en = en; v.dir = dir;
    return v;
  endfunction

  // Reference ALU from the opcode definitions, plain arithmetic
  function automatic res_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t o;
    longint unsigned s;
    o.r = 0; o.c = 0;
    case (op)
      4'd0: o.r = a & b;
      4'd1: o.r = a | b;
      4'd2: begin s = longint'(a) + longint'(b); o.r = s[31:0]; o.c = (s >= 64'h1_0000_0000); end
      4'd3: begin o.r = a - b; o.c = (a < b); end
      4'd4: o.r = (a < b) ? 32'd1 : 32'd0;
      4'd5: o.r = ~(a | b);
      4'd6: o.r = a ^ b;
      4'd7: o.r = a << (b % 32);
      4'd8: o.r = a >> (b % 32);
      default: o.r = 0;
    endcase
    o.z = (o.r == 0);
    return o;
  endfunction

  function automatic logic [31:0] pickv();
    case ($urandom % 5)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h1;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic load(input logic [3:0] d, input logic [31:0] v);
    @(negedge clk);
    carga_en = 1'b1; carga_dir = d; carga_dato = v;
    @(posedge clk);
    #1 carga_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ovalid"}, out_valido, 0);
    chk({tag, "_salida"}, salida, 0);
    chk({tag, "_z"}, Zflag, 0);
    chk({tag, "_c"}, Cflag, 0);
    chk({tag, "_cnt"}, contador_ops, 0);
    chk({tag, "_inlisto"}, in_listo, 1);
    for (int i = 0; i < 16; i++) begin
      rd_dir = i[3:0];
      #1 chk({tag, "_ram"}, rd_dato, 0);
    end
  endtask

  initial begin
    logic [31:0] held;
    logic        hold_pending;
    int          mcnt;
    res_t        e, got;

    rst_n = 1'b0; instruccion = '0; in_valido = 1'b0; carga_en = 1'b0;
    carga_dir = '0; carga_dato = '0; rd_dir = '0; out_listo = 1'b1;

    tv[0]  = mk(4'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0, 0, 1, 4'd0);
    tv[1]  = mk(4'd1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 0, 0, 1, 4'd1);
    tv[2]  = mk(4'd2, 32'd5,         32'd7,         32'd12,        0, 0, 1, 4'd2);
    tv[3]  = mk(4'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 1, 1, 4'd3);
    tv[4]  = mk(4'd3, 32'd1,         32'hFFFF_FFFF, 32'd2,         0, 1, 1, 4'd4);
    tv[5]  = mk(4'd3, 32'd5,         32'd5,         32'd0,         1, 0, 0, 4'd2);
    tv[6]  = mk(4'd4, 32'd3,         32'd9,         32'd1,         0, 0, 1, 4'd6);
    tv[7]  = mk(4'd4, 32'd9,         32'd3,         32'd0,         1, 0, 1, 4'd7);
    tv[8]  = mk(4'd4, 32'hFFFF_FFFF, 32'd1,         32'd0,         1, 0, 1, 4'd8);
    tv[9]  = mk(4'd5, 32'd0,         32'd0,         32'hFFFF_FFFF, 0, 0, 1, 4'd9);
    tv[10] = mk(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 0, 0, 1, 4'd10);
    tv[11] = mk(4'd7, 32'd1,         32'd31,        32'h8000_0000, 0, 0, 1, 4'd11);
    tv[12] = mk(4'd7, 32'd3,         32'h21,        32'd6,         0, 0, 1, 4'd12);
    tv[13] = mk(4'd8, 32'h8000_0000, 32'd31,        32'd1,         0, 0, 1, 4'd13);
    tv[14] = mk(4'd9, 32'd5,         32'd7,         32'd0,         1, 0, 1, 4'd14);
    tv[15] = mk(4'hF, 32'd5,         32'd7,         32'd0,         1, 0, 1, 4'd15);
    for (int i = 0; i < 16; i++) mram[i] = 0;

    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    rst_n = 1'b1;

    // Directed table: A from bank[2], B from bank[3]
    for (int i = 0; i < 16; i++) begin
      load(4'd2, tv[i].a);
      load(4'd3, tv[i].b);
      @(negedge clk);
      instruccion = mk_ins(tv[i].dir, tv[i].op, 4'd2, 4'd3, tv[i].en);
      in_valido = 1'b1;
      #1 chk("tv_inlisto", in_listo, 1);
      @(negedge clk);
      in_valido = 1'b0;
      chk("tv_lat1", out_valido, 0);
      @(negedge clk);
      chk("tv_lat2", out_valido, 1);
      chk("tv_salida", salida, tv[i].exp);
      chk("tv_z", Zflag, tv[i].z);
      chk("tv_c", Cflag, tv[i].c);
      if (tv[i].en) mram[tv[i].dir] = tv[i].exp;
      rd_dir = tv[i].dir;
      #1 chk("tv_ram", rd_dato, mram[tv[i].dir]);
    end
    @(negedge clk);
    chk("tv_cnt", contador_ops, 16);

    // Backpressure: bank[2]=5, bank[3]=7 remain from the last vector
    out_listo = 1'b0; in_valido = 1'b1;
    instruccion = mk_ins(4'd0, 4'd2, 4'd3, 4'd2, 1'b0);
    #1 chk("bp_rdy0", in_listo, 1);
    @(negedge clk);
    instruccion = mk_ins(4'd0, 4'd3, 4'd3, 4'd2, 1'b0);
    #1 chk("bp_rdy1", in_listo, 1);
    @(negedge clk);
    instruccion = mk_ins(4'd0, 4'd1, 4'd3, 4'd2, 1'b0);
    #1 chk("bp_rdy2", in_listo, 0);
    chk("bp_ov", out_valido, 1);
    chk("bp_res0", salida, 12);
    @(negedge clk);
    chk("bp_hold", salida, 12);
    chk("bp_hold_ov", out_valido, 1);
    chk("bp_rdy2b", in_listo, 0);
    out_listo = 1'b1;
    #1 chk("bp_rdy3", in_listo, 1);
    @(negedge clk);
    in_valido = 1'b0;
    chk("bp_res1", salida, 2);
    @(negedge clk);
    chk("bp_res2", salida, 7);
    @(negedge clk);
    chk("bp_empty", out_valido, 0);
    chk("bp_cnt", contador_ops, 19);

    // Load and capture of the same bank address on one edge
    carga_en = 1'b1; carga_dir = 4'd2; carga_dato = 32'd100;
    instruccion = mk_ins(4'd7, 4'd2, 4'd2, 4'd3, 1'b1); in_valido = 1'b1;
    @(negedge clk);
    carga_en = 1'b0;
    instruccion = mk_ins(4'd8, 4'd2, 4'd2, 4'd3, 1'b1);
    @(negedge clk);
    in_valido = 1'b0;
    chk("col_old", salida, 12);
    @(negedge clk);
    chk("col_new", salida, 107);
    rd_dir = 4'd7;
    #1 chk("col_ram", rd_dato, 12);

    // Reset with two operations in flight
    @(negedge clk);
    out_listo = 1'b0; in_valido = 1'b1;
    instruccion = mk_ins(4'd5, 4'd2, 4'd2, 4'd3, 1'b1);
    @(negedge clk);
    instruccion = mk_ins(4'd6, 4'd2, 4'd2, 4'd3, 1'b1);
    @(negedge clk);
    in_valido = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; out_listo = 1'b1;
    check_reset_state("rst1");

    // Randomized traffic against the transaction-level model
    for (int i = 0; i < 16; i++) begin mbank[i] = 0; mram[i] = 0; end
    mcnt = 0; hold_pending = 1'b0; held = 0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(negedge clk);
      if (hold_pending) begin
        chk("rnd_hold_ov", out_valido, 1);
        chk("rnd_hold_val", salida, held);
      end
      in_valido   = (cyc < 600) ? ($urandom % 3 != 0) : 1'b0;
      out_listo   = (cyc < 600) ? ($urandom % 4 != 0) : 1'b1;
      instruccion = mk_ins($urandom, $urandom_range(0, 15), $urandom, $urandom, $urandom);
      carga_en    = (cyc < 600) ? ($urandom % 3 == 0) : 1'b0;
      carga_dir   = $urandom;
      carga_dato  = pickv();
      #1;
      if (out_valido && out_listo) begin
        if (exp_q.size() == 0) begin
          chk("rnd_extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_salida", salida, e.r);
          chk("rnd_z", Zflag, e.z);
          chk("rnd_c", Cflag, e.c);
        end
        mcnt++;
      end
      hold_pending = out_valido & ~out_listo;
      held = salida;
      if (in_valido && in_listo) begin
        got = ref_alu(instruccion[12:9], mbank[instruccion[8:5]], mbank[instruccion[4:1]]);
        exp_q.push_back(got);
        if (instruccion[0]) mram[instruccion[16:13]] = got.r;
      end
      if (carga_en) mbank[carga_dir] = carga_dato;
    end
    @(negedge clk);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_cnt", contador_ops, mcnt % 65536);
    for (int i = 0; i < 16; i++) begin
      rd_dir = i[3:0];
      #1 chk("rnd_ram", rd_dato, mram[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
